ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ACCESS_WAIT, default 0, sets extra STROBE cycles per access (0..7).
REQ-002 Parameter FIXED_PRIORITY, default 0: 0 = round-robin, 1 = port 0 always wins.
REQ-003 Clock  input  1  system clock; all state on posedge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Req0 / Req1  input  1 each  access request, held until the matching Ack.
REQ-006 Addr0 / Addr1  input  16 each  RAM address.
REQ-007 WData0 / WData1  input  8 each  write data.
REQ-008 Write0 / Write1  input  1 each  1 = write, 0 = read.
REQ-009 Ack0 / Ack1  output  1 each  one-cycle completion pulse.
REQ-010 RData0 / RData1  output  8 each  read data, valid with Ack, held until the next read Ack on that port.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Grant  output  2  one-hot owner of the current access; 00 in IDLE.
REQ-013 MemAddr  output  16  RAM address.
REQ-014 MemData  inout  8  RAM data bus; driven only by write accesses, otherwise high-Z.
REQ-015 MemClk  output  1  RAM clock strobe.
REQ-016 MemWrite  output  1  RAM ReadWrite line, 1 = write.

Function
REQ-017 FSM states, one per access: IDLE -> SETUP -> STROBE (1+ACCESS_WAIT cycles) -> CAPTURE -> DONE -> IDLE.
REQ-018 IDLE with no Req stays in IDLE; any Req high at a posedge registers Grant and the request fields, then moves to SETUP.
REQ-019 Simultaneous Req, round-robin mode: the port not granted last wins; after reset port 0 is treated as last-granted, so port 1 wins the first tie.
REQ-020 Simultaneous Req, FIXED_PRIORITY=1: port 0 wins.
REQ-021 SETUP: MemAddr = latched address; MemWrite = latched Write; MemClk = 0; MemData driven with latched WData for writes.
REQ-022 STROBE: MemClk = 1; address, MemWrite and write data stay stable.
REQ-023 CAPTURE: MemClk = 0; for reads, MemData is sampled into the granted RData register at the end of the cycle.
REQ-024 DONE: MemData high-Z, MemWrite = 0, granted Ack = 1 for exactly this cycle.
REQ-025 Latency: Ack is asserted 4+ACCESS_WAIT cycles after the posedge that samples Req in IDLE.
REQ-026 Back-to-back accesses take at least 5+ACCESS_WAIT cycles; the IDLE cycle is mandatory bus turnaround.
REQ-027 A Req dropped mid-access does not abort the access, and Ack is still issued.
REQ-028 A Req still high in the cycle after its Ack is a new request.
REQ-029 Requester inputs are sampled only in IDLE; later changes have no effect on the current access.
REQ-030 A write access leaves RData unchanged.
REQ-031 MemClk is a registered output and never glitches.
REQ-032 MemAddr holds its last value outside accesses.

Reset
REQ-033 Reset low forces IDLE at once, without waiting for Clock.
REQ-034 Reset low drives MemClk = 0, MemWrite = 0, MemData high-Z, Ack0 = Ack1 = 0, Grant = 00, Busy = 0.
REQ-035 Reset low clears MemAddr, RData0 and RData1 to 0 and the round-robin pointer to port 0.
REQ-036 An access cut by reset is abandoned, with no Ack after reset releases.

Structure
REQ-037 The shared synth package holds the FSM state encoding, the 16-bit address width constant and the 8-bit data width constant.
REQ-038 One sub-module, rr_arbiter2, contains the two-input grant logic, last-grant pointer and FIXED_PRIORITY option.
REQ-039 The MemData tristate sits only in the top level.

Verification
REQ-040 Single write: Req0, Addr0=16'h0010, WData0=8'hA5, Write0=1 -> MemWrite=1 with MemData=A5 through one MemClk pulse; Ack0 4 cycles later.
REQ-041 Read-back: Req1, Addr1=16'h0010, Write1=0 -> Ack1 after 4 cycles; RData1=8'hA5; MemData high-Z in DONE.
REQ-042 Contention, round-robin: Req0 and Req1 held high continuously -> grants alternate 1,0,1,0; Ack every 5 cycles.
REQ-043 Contention, FIXED_PRIORITY=1 with both held -> only port 0 is acked.
REQ-044 ACCESS_WAIT=3, one read -> MemClk high for 4 cycles; Ack 7 cycles after the request.
REQ-045 Reset low during STROBE of a write -> MemClk=0, MemData=Z and Busy=0 asynchronously; no Ack after release.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths and FSM state encoding for the two-port RAM arbiter.
package ram_arbiter_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_CAPTURE,
        ST_DONE
    } state_e;
endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input grant logic with last-grant pointer and optional fixed priority.
module rr_arbiter2
    import ram_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);
    logic last_q;
    // last_q set means port 1 was granted last, so port 0 wins the next tie
    always_comb gnt_o = (req_i == 2'b11) ? ((FIXED_PRIORITY || last_q) ? 2'b01 : 2'b10) : req_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b0;
        else if (take_i) last_q <= gnt_o[1];
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one strobed RAM between two requesters, one access at a time.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_WAIT    = 0,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              write0_i,
    input  logic              write1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              busy_o,
    output logic [1:0]        grant_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    inout  wire  [DATA_W-1:0] mem_data_io,
    output logic              mem_clk_o,
    output logic              mem_write_o
);
    localparam logic [2:0] WAIT_LAST = 3'(ACCESS_WAIT);
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d, gnt, ack_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata1_q;
    logic              wr_q, wr_d, mem_clk_q, mem_write_q, oe_q, take, in_access;

    assign take      = (state_q == ST_IDLE) && (req0_i || req1_i);
    assign in_access = state_d inside {ST_SETUP, ST_STROBE, ST_CAPTURE};

    rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({req1_i, req0_i}),
        .take_i(take),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: if (take) begin
                state_d = ST_SETUP;
                grant_d = gnt;
                addr_d  = gnt[1] ? addr1_i : addr0_i;
                wdata_d = gnt[1] ? wdata1_i : wdata0_i;
                wr_d    = gnt[1] ? write1_i : write0_i;
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = 3'd0;
            end
            ST_STROBE: begin
                state_d = (cnt_q == WAIT_LAST) ? ST_CAPTURE : ST_STROBE;
                cnt_d   = cnt_q + 3'd1;
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus-facing strobes are decoded from the next state so they leave the flops glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            mem_clk_q   <= 1'b0;
            mem_write_q <= 1'b0;
            oe_q        <= 1'b0;
            ack_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            mem_clk_q   <= state_d == ST_STROBE;
            mem_write_q <= wr_d && in_access;
            oe_q        <= wr_d && in_access;
            ack_q       <= (state_d == ST_DONE) ? grant_q : 2'b00;
            if (state_q == ST_CAPTURE && !wr_q) begin
                if (grant_q[0]) rdata0_q <= mem_data_io;
                if (grant_q[1]) rdata1_q <= mem_data_io;
            end
        end
    end

    assign mem_data_io = oe_q ? wdata_q : 'z;
    assign mem_addr_o  = addr_q;
    assign mem_clk_o   = mem_clk_q;
    assign mem_write_o = mem_write_q;
    assign grant_o     = grant_q;
    assign busy_o      = |grant_q;
    assign ack0_o      = ack_q[0];
    assign ack1_o      = ack_q[1];
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
endmodule
